// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array datapath: move-drain FSM encoding
// and the default word width common to sa_cell and its drain.
package sa_pkg;

    localparam int SA_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2
    } drain_state_t;

endpackage

// File: rtl/sa_move_drain_if.sv
// Port bundle of sa_move_drain: tile control, the unstallable move-buffer
// input, the valid/ready result stream and the sticky error flags.
interface sa_move_drain_if
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  tile_len;
    logic [DATA_WIDTH-1:0] move_buff_out;
    logic                  move_buff_out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic                  busy;
    logic                  tile_done;
    logic                  overflow;
    logic                  stray;
    logic                  clear_err;

    // master drives the block (column + result writer side), slave is the drain
    modport master (
        output start, tile_len, move_buff_out, move_buff_out_valid, out_ready, clear_err,
        input  out_data, out_valid, out_last, busy, tile_done, overflow, stray
    );

    modport slave (
        input  start, tile_len, move_buff_out, move_buff_out_valid, out_ready, clear_err,
        output out_data, out_valid, out_last, busy, tile_done, overflow, stray
    );
endinterface

// File: rtl/sa_sync_fifo.sv
// Synchronous show-ahead FIFO; write visible on the read side one edge after push.
// A push while full is dropped unless a pop happens in the same cycle.
module sa_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_fire, pop_fire;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    // Head is forced to zero when empty so stale entries never leak out.
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_fire  = pop && !empty;
        push_fire = push && (!full || pop_fire);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/sa_move_drain.sv
// Frames the unstallable move-buffer stream into tiles, buffers it and re-issues
// it on a valid/ready stream; 1 cycle in-to-out, overflow/stray words flagged sticky.
module sa_move_drain
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    sa_move_drain_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    drain_state_t          state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, rx_cnt_q, rx_cnt_d;
    logic                  overflow_q, overflow_d, stray_q, stray_d;
    logic                  push, fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH:0]   push_dat, pop_dat;
    logic                  accept_start, last_word, ovf_evt, stray_evt;

    assign accept_start = bus.start && (bus.tile_len != '0);
    assign last_word    = (rx_cnt_q == len_q - LEN_WIDTH'(1));
    assign push_dat     = {last_word, bus.move_buff_out};

    sa_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (bus.out_ready),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (accept_start) state_d = ST_COLLECT;
            // A dropped last word still closes the tile.
            ST_COLLECT: if (bus.move_buff_out_valid && last_word) state_d = ST_FLUSH;
            ST_FLUSH:   if (fifo_count == '0) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push          = (state_q == ST_COLLECT) && bus.move_buff_out_valid;
        bus.busy      = (state_q != ST_IDLE);
        bus.tile_done = (state_q == ST_FLUSH) && (fifo_count == '0);
    end

    // A full FIFO always has a head, so out_ready alone means a pop frees a slot.
    assign ovf_evt   = push && fifo_full && !bus.out_ready;
    assign stray_evt = bus.move_buff_out_valid && (state_q != ST_COLLECT);

    always_comb begin
        len_d      = len_q;
        rx_cnt_d   = rx_cnt_q;
        overflow_d = bus.clear_err ? 1'b0 : overflow_q;
        stray_d    = bus.clear_err ? 1'b0 : stray_q;
        if ((state_q == ST_IDLE) && accept_start) begin
            len_d    = bus.tile_len;
            rx_cnt_d = '0;
        end
        if (push) rx_cnt_d = rx_cnt_q + LEN_WIDTH'(1);
        if (ovf_evt)   overflow_d = 1'b1;
        if (stray_evt) stray_d    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            rx_cnt_q   <= '0;
            overflow_q <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            len_q      <= len_d;
            rx_cnt_q   <= rx_cnt_d;
            overflow_q <= overflow_d;
            stray_q    <= stray_d;
        end
    end

    assign bus.out_data  = pop_dat[DATA_WIDTH-1:0];
    assign bus.out_last  = pop_dat[DATA_WIDTH];
    assign bus.out_valid = !fifo_empty;
    assign bus.overflow  = overflow_q;
    assign bus.stray     = stray_q;
endmodule

// File: tb/tb_sa_move_drain.sv
// Bench for sa_move_drain: directed tiles plus random traffic, scored against a
// queue-based tile model; a negedge monitor compares every visible output.
module tb_sa_move_drain;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sa_move_drain_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    sa_move_drain #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words the block should currently be holding, in order.
    word_t exp_q[$];
    int    m_phase = 0;   // 0 idle, 1 collecting a tile, 2 waiting for drain
    int    m_left  = 0;   // words still owed by the current tile
    bit    m_ovf   = 1'b0;
    bit    m_stray = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        int    pre_size;
        bit    pop, ovf_ev, stray_ev;
        int    nxt;
        word_t w;
        if (!rst) begin
            exp_q.delete();
            m_phase = 0;
            m_left  = 0;
            m_ovf   = 1'b0;
            m_stray = 1'b0;
        end else begin
            pre_size = exp_q.size();
            pop      = bus.out_ready && (pre_size > 0);
            ovf_ev   = 1'b0;
            stray_ev = 1'b0;
            nxt      = m_phase;
            if (pop) void'(exp_q.pop_front());
            if (m_phase == 1 && bus.move_buff_out_valid) begin
                w.d = bus.move_buff_out;
                w.l = (m_left == 1);
                if (pre_size < DEPTH || pop) exp_q.push_back(w);
                else                         ovf_ev = 1'b1;
                m_left--;
                if (m_left == 0) nxt = 2;
            end else if (bus.move_buff_out_valid) begin
                stray_ev = 1'b1;
            end
            if (m_phase == 0 && bus.start && bus.tile_len != 0) begin
                nxt    = 1;
                m_left = int'(bus.tile_len);
            end
            if (m_phase == 2 && pre_size == 0) nxt = 0;
            m_phase = nxt;
            if (bus.clear_err) begin
                m_ovf   = 1'b0;
                m_stray = 1'b0;
            end
            if (ovf_ev)   m_ovf   = 1'b1;
            if (stray_ev) m_stray = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", bus.out_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("out_data", bus.out_data, exp_q[0].d);
            chk("out_last", bus.out_last, exp_q[0].l);
        end
        chk("busy",      bus.busy,      m_phase != 0);
        chk("tile_done", bus.tile_done, (m_phase == 2) && (exp_q.size() == 0));
        chk("overflow",  bus.overflow,  m_ovf);
        chk("stray",     bus.stray,     m_stray);
    end

    task automatic drive(input bit st, input int len, input bit vld,
                         input logic [DW-1:0] d, input bit rdy, input bit clr);
        bus.start               = st;
        bus.tile_len            = LW'(len);
        bus.move_buff_out_valid = vld;
        bus.move_buff_out       = d;
        bus.out_ready           = rdy;
        bus.clear_err           = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            drive(0, 0, 0, '0, 1, 0);
            n++;
        end
        n_checks++;
        if (bus.busy) begin
            n_fail++;
            $display("FAIL %s: busy still %0d after %0d cycles, required 0", name, bus.busy, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        bus.start = 0; bus.tile_len = '0; bus.move_buff_out = '0;
        bus.move_buff_out_valid = 0; bus.out_ready = 0; bus.clear_err = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b1;

        // Three-word tile straight through
        drive(1, 3, 0, '0, 1, 0);
        drive(0, 0, 1, 32'h3F800000, 1, 0);
        drive(0, 0, 1, 32'h40000000, 1, 0);
        drive(0, 0, 1, 32'h40400000, 1, 0);
        wait_idle("t1_done", 20);

        // Overflow: 20 words into 16 entries with no drain
        drive(1, 20, 0, '0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, DW'(i), 0, 0);
        chk("t2_overflow", bus.overflow, 1);
        chk("t2_busy", bus.busy, 1);
        drive(0, 0, 0, '0, 0, 0);
        wait_idle("t2_done", 40);
        drive(0, 0, 0, '0, 1, 1);
        chk("t2_clear", bus.overflow, 0);

        // Push and pop together while full
        drive(1, 17, 0, '0, 0, 0);
        for (int i = 0; i < 16; i++) drive(0, 0, 1, 32'h100 + DW'(i), 0, 0);
        drive(0, 0, 1, 32'hA5A5A5A5, 1, 0);
        chk("t3_no_overflow", bus.overflow, 0);
        chk("t3_still_valid", bus.out_valid, 1);
        wait_idle("t3_done", 40);

        // Stray word in IDLE, then clear
        drive(0, 0, 1, 32'hDEADBEEF, 1, 0);
        chk("t4_stray", bus.stray, 1);
        chk("t4_no_out", bus.out_valid, 0);
        drive(0, 0, 0, '0, 1, 1);
        chk("t4_clear", bus.stray, 0);

        // Asynchronous reset mid-tile
        drive(1, 4, 0, '0, 0, 0);
        drive(0, 0, 1, 32'h11, 0, 0);
        drive(0, 0, 1, 32'h22, 0, 0);
        rst = 1'b0;
        #1;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_done", bus.tile_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 1, 0, '0, 1, 0);
        drive(0, 0, 1, 32'h1, 1, 0);
        wait_idle("t5_tile1", 20);

        // Zero-length start ignored; restart during COLLECT ignored
        drive(1, 0, 0, '0, 1, 0);
        chk("t6_len0_busy", bus.busy, 0);
        drive(1, 5, 0, '0, 1, 0);
        drive(0, 0, 1, 32'h51, 1, 0);
        drive(0, 0, 1, 32'h52, 1, 0);
        drive(1, 2, 1, 32'h53, 1, 0);
        drive(0, 0, 1, 32'h54, 1, 0);
        chk("t6_busy_mid", bus.busy, 1);
        drive(0, 0, 1, 32'h55, 1, 0);
        wait_idle("t6_done", 20);

        // Random tiles with bursty input, random drain and stray/clear noise
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                drive(0, 0, ($urandom % 8) == 0, $urandom, $urandom % 2, ($urandom % 6) == 0);
            drive(1, int'($urandom_range(1, 24)), 0, '0, $urandom % 2, 0);
            begin
                int n;
                n = 0;
                while (bus.busy && n < 400) begin
                    drive(($urandom % 20) == 0, int'($urandom_range(0, 9)), ($urandom % 3) != 0,
                          $urandom, ($urandom % 4) != 0, ($urandom % 16) == 0);
                    n++;
                end
                n_checks++;
                if (bus.busy) begin
                    n_fail++;
                    $display("FAIL rand_tile%0d: busy still 1 after 400 cycles, required 0", t);
                end
            end
        end

        repeat (4) drive(0, 0, 0, '0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_move_drain.md
Name: sa_move_drain

Overview:
- Receiving end of the systolic-array move-buffer path: sinks the `move_buff_out` / `move_buff_out_valid` stream leaving the bottom cell of an `sa_cell` column.
- That stream has no backpressure. The block frames it into tiles of a programmed length, buffers it in a FIFO, and re-issues it on a valid/ready stream towards the result writer.
- Each word carries a last-of-tile tag. Overflow and stray words are flagged as sticky errors.

Parameters:
- DATA_WIDTH, 32, width of one move-buffer word (IEEE-754 single).
- FIFO_DEPTH, 16, buffer entries; must be a power of two, at least 2.
- LEN_WIDTH, 8, width of `tile_len`; maximum tile is 2^LEN_WIDTH-1 words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; arms collection of one tile.
- tile_len  in  LEN_WIDTH  words expected in the tile; sampled when `start` is accepted.
- move_buff_out  in  DATA_WIDTH  word from the column's last `sa_cell`.
- move_buff_out_valid  in  1  `move_buff_out` is valid this cycle; cannot be stalled.
- out_data  out  DATA_WIDTH  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_last  out  1  head word is the final word of its tile.
- out_ready  in  1  downstream accepts; pop when `out_valid && out_ready`.
- busy  out  1  state is not IDLE.
- tile_done  out  1  one-cycle pulse at end of FLUSH.
- overflow  out  1  sticky: a word arrived while the FIFO was full.
- stray  out  1  sticky: a valid word arrived outside COLLECT.
- clear_err  in  1  synchronous clear of `overflow` and `stray`.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE; FIFO pointers and count = 0; rx_cnt=0.
  - All outputs 0, including `out_data`.
  - Reset mid-tile discards all buffered data.
- States: IDLE, COLLECT, FLUSH.
- IDLE:
  - `start` with `tile_len` != 0 → latch len, rx_cnt=0, go to COLLECT next cycle.
  - `start` with `tile_len` == 0 is ignored.
- COLLECT:
  - Each cycle `move_buff_out_valid`=1 → push `{move_buff_out, last}` with last = (rx_cnt == len-1); rx_cnt+1.
  - After the word with last=1, go to FLUSH.
  - `start` is ignored while not in IDLE.
- FLUSH:
  - Wait until the FIFO is empty, with no push or pop pending.
  - Then assert `tile_done` for one cycle and go to IDLE.
  - A new `start` is accepted the cycle after `tile_done`.
- Latency: a word sampled at edge N is visible on `out_data` / `out_valid` after edge N (registered write, show-ahead read). Minimum 1 cycle input-to-output.
- Full FIFO:
  - Push while count==FIFO_DEPTH with no simultaneous pop → word dropped, `overflow` set, rx_cnt still increments so tile framing holds.
  - If the dropped word carried last=1, the FSM still goes to FLUSH; `out_last` for that tile is lost.
  - Push and pop in the same cycle while full → both succeed; count unchanged; no overflow.
- Empty FIFO: `out_ready` with `out_valid`=0 is a no-op.
- Pointers wrap modulo FIFO_DEPTH. count spans 0..FIFO_DEPTH and uses $clog2(FIFO_DEPTH)+1 bits.
- Valid word in IDLE or FLUSH → dropped, `stray` set.
- `clear_err` in the same cycle as a new error event: the error wins and the flag stays 1.
- No arithmetic on data; words pass bit-exact.

Decomposition:
- Shared package `sa_pkg` holds:
  - the state encoding constants (IDLE=0, COLLECT=1, FLUSH=2);
  - DATA_WIDTH default, shared with `sa_cell`.
- One natural sub-module: `sa_sync_fifo`, a parameterised width/depth synchronous FIFO. It provides push/pop and full/empty/count, stores DATA_WIDTH+1 bits (data plus last tag), and has the same async active-low `rst`.
- FSM and tile counter live in `sa_move_drain`.

Test Plan:
- Reset release, then `start` with tile_len=3. Inject 3F800000, 40000000, 40400000 on consecutive cycles with `out_ready`=1. Required:
  - three outputs in order, each one cycle after its input;
  - `out_last`=1 only on 40400000;
  - `tile_done` pulse after the last pop; `busy` returns to 0.
- `out_ready`=0, tile_len=20, 20 consecutive valid words 0..19. Required:
  - FIFO holds words 0..15;
  - `overflow`=1; words 16..19 dropped;
  - state goes to FLUSH;
  - raising `out_ready` drains 0..15 with `out_last`=0 throughout, then `tile_done`.
- FIFO full with `out_ready`=1 and a valid input in the same cycle → count stays 16, no overflow, input word appears after the 16 older words.
- Valid word 0xDEADBEEF while IDLE → not output, `stray`=1. `clear_err` pulse → `stray`=0.
- Assert `rst`=0 mid-COLLECT after 2 of 4 words → `out_valid`, `busy` and `tile_done` are 0 immediately (asynchronous). After release, `start` tile_len=1 with word 0x1 → single output, `out_last`=1.
- `start` with tile_len=0 → remains IDLE, `busy`=0. A second `start` pulsed during COLLECT does not restart rx_cnt.
